// File: rtl/rgmii_tx_framer_if.sv
// Byte-stream handshake between a packet source and the RGMII transmit framer.
// The source owns data/valid/last; the framer answers with ready.
interface rgmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/rgmii_tx_framer.sv
// Gigabit MAC transmit sequencer: preamble/SFD, data, zero pad, CRC-32 FCS and IFG,
// producing one registered 10-bit ODDR word per clk for the rgmii_tx block.
module rgmii_tx_framer #(
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12,
  parameter int PRE_LEN = 7
) (
  input  logic               clk,
  input  logic               rst,
  rgmii_tx_framer_if.slave   src,
  output logic [9:0]         tx_din,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [31:0] POLY      = 32'hEDB88320;
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
  localparam logic [15:0] PRE_LAST  = 16'(PRE_LEN - 1);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_LEN - 1);
  localparam logic [9:0]  ERR_WORD  = 10'h010;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [10:0] len, len_nx;
  logic [10:0] len_inc;
  logic [11:0] len_after;
  logic [31:0] crc, crc_nx;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic [9:0]  tx_nx;
  logic        done_nx;
  logic        under_nx;

  // Reflected CRC-32, one input bit per iteration, LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  // ODDR word: low nibble + TX_EN on the rising edge, high nibble + EN^ER on the falling edge.
  function automatic logic [9:0] enc(input logic [7:0] b);
    return {1'b1, b[7:4], 1'b1, b[3:0]};
  endfunction

  assign src.s_ready = (state == DATA);
  assign busy        = (state != IDLE);
  assign len_inc     = (len == 11'h7FF) ? len : len + 11'd1;
  assign len_after   = {1'b0, len} + 12'd1;
  assign fcs_word    = ~crc;

  always_comb begin
    fcs_byte = 8'h00;
    unique case (cnt[1:0])
      2'd0: fcs_byte = fcs_word[7:0];
      2'd1: fcs_byte = fcs_word[15:8];
      2'd2: fcs_byte = fcs_word[23:16];
      2'd3: fcs_byte = fcs_word[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      crc        <= '1;
      tx_din     <= '0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      len        <= len_nx;
      crc        <= crc_nx;
      tx_din     <= tx_nx;
      frame_done <= done_nx;
      underrun   <= under_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    len_nx   = len;
    crc_nx   = crc;
    tx_nx    = '0;
    done_nx  = 1'b0;
    under_nx = 1'b0;

    unique case (state)
      IDLE: begin
        if (src.s_valid) begin
          state_nx = PRE;
          cnt_nx   = '0;
        end
      end

      PRE: begin
        tx_nx = enc(8'h55);
        if (cnt == PRE_LAST) begin
          state_nx = SFD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      SFD: begin
        tx_nx    = enc(8'hD5);
        crc_nx   = '1;
        len_nx   = '0;
        state_nx = DATA;
      end

      DATA: begin
        if (src.s_valid) begin
          tx_nx  = enc(src.s_data);
          crc_nx = crc_step(crc, src.s_data);
          len_nx = len_inc;
          if (src.s_last) begin
            cnt_nx   = '0;
            state_nx = (len_after < MIN_LEN_W) ? PAD : FCS;
          end
        end else begin
          // Source starved mid-frame: one error symbol, then drop the frame without FCS.
          tx_nx    = ERR_WORD;
          under_nx = 1'b1;
          cnt_nx   = '0;
          state_nx = IFG;
        end
      end

      PAD: begin
        tx_nx  = enc(8'h00);
        crc_nx = crc_step(crc, 8'h00);
        len_nx = len_inc;
        if (len_after >= MIN_LEN_W) begin
          cnt_nx   = '0;
          state_nx = FCS;
        end
      end

      FCS: begin
        tx_nx = enc(fcs_byte);
        if (cnt[1:0] == 2'd3) begin
          done_nx  = 1'b1;
          cnt_nx   = '0;
          state_nx = IFG;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      IFG: begin
        // The last gap cycle doubles as the idle sample, so back-to-back frames see exactly IFG_LEN idle bytes.
        if (cnt == IFG_LAST) begin
          cnt_nx   = '0;
          state_nx = src.s_valid ? PRE : IDLE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end

      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed bench for rgmii_tx_framer: a padding instance (MIN_LEN=60) and a raw instance (MIN_LEN=0)
// are driven from one byte source and compared cycle by cycle against an expected record list.
module tb_rgmii_tx_framer;

  localparam int IFG_N = 12;
  localparam int PRE_N = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #4 clk = ~clk;

  rgmii_tx_framer_if bus_pad ();
  rgmii_tx_framer_if bus_raw ();

  logic [9:0] tx_pad, tx_raw;
  logic       busy_pad, busy_raw, done_pad, done_raw, under_pad, under_raw;

  rgmii_tx_framer dut_pad (
    .clk        (clk),
    .rst        (rst),
    .src        (bus_pad.slave),
    .tx_din     (tx_pad),
    .busy       (busy_pad),
    .frame_done (done_pad),
    .underrun   (under_pad)
  );

  rgmii_tx_framer #(.MIN_LEN(0)) dut_raw (
    .clk        (clk),
    .rst        (rst),
    .src        (bus_raw.slave),
    .tx_din     (tx_raw),
    .busy       (busy_raw),
    .frame_done (done_raw),
    .underrun   (under_raw)
  );

  int         sel = 0;
  logic       drv_valid = 1'b0;
  logic       drv_last = 1'b0;
  logic [7:0] drv_data = 8'h00;

  assign bus_pad.s_valid = (sel == 0) && drv_valid;
  assign bus_pad.s_last  = drv_last;
  assign bus_pad.s_data  = drv_data;
  assign bus_raw.s_valid = (sel == 1) && drv_valid;
  assign bus_raw.s_last  = drv_last;
  assign bus_raw.s_data  = drv_data;

  logic [9:0] cur_tx;
  logic       cur_ready, cur_busy, cur_done, cur_under;
  always_comb begin
    if (sel == 1) begin
      cur_tx = tx_raw; cur_ready = bus_raw.s_ready; cur_busy = busy_raw;
      cur_done = done_raw; cur_under = under_raw;
    end else begin
      cur_tx = tx_pad; cur_ready = bus_pad.s_ready; cur_busy = busy_pad;
      cur_done = done_pad; cur_under = under_pad;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle records: output word of the cycle plus ready/busy/pulses.
  logic [9:0] r_out[$];
  bit         r_ready[$], r_busy[$], r_done[$], r_under[$];

  task automatic add_rec(input logic [9:0] o, input bit rdy, input bit bsy, input bit dn, input bit ur);
    r_out.push_back(o); r_ready.push_back(rdy); r_busy.push_back(bsy);
    r_done.push_back(dn); r_under.push_back(ur);
  endtask

  function automatic logic [9:0] enc(input logic [7:0] b);
    return {1'b1, b[7:4], 1'b1, b[3:0]};
  endfunction

  function automatic logic [31:0] sw_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  logic [7:0] stream[$];
  bit         stream_last[$];
  int         idx;
  bit         hs_prev;
  bit         dropped;

  task automatic drive_step(input int drop_at);
    if (hs_prev) idx++;
    if (!dropped && idx < stream.size()) begin
      if (drop_at >= 0 && idx == drop_at && cur_ready) begin
        drv_valid = 1'b0; drv_last = 1'b0; dropped = 1'b1;
      end else begin
        drv_valid = 1'b1; drv_data = stream[idx]; drv_last = stream_last[idx];
      end
    end else begin
      drv_valid = 1'b0; drv_last = 1'b0;
    end
    hs_prev = drv_valid && cur_ready;
  endtask

  // Called on a falling edge with the selected DUT idle; frame r carries frm[i]+r.
  task automatic applyStimulus(input string tag, input logic [7:0] frm[$], input int reps,
                               input int drop_at, input int min_len,
                               input bit use_fixed, input logic [31:0] fixed_fcs);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    logic [7:0]  b;
    bit          aborted;
    int          n;
    n = frm.size();
    stream.delete(); stream_last.delete();
    r_out.delete(); r_ready.delete(); r_busy.delete(); r_done.delete(); r_under.delete();
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < n; i++) begin
        stream.push_back(frm[i] + 8'(r));
        stream_last.push_back(i == n - 1);
      end

    add_rec(10'h000, 0, 0, 0, 0);
    for (int r = 0; r < reps; r++) begin
      aborted = 1'b0;
      body.delete();
      for (int p = 0; p < PRE_N; p++) add_rec(10'h2B5, 0, 1, 0, 0);
      add_rec(enc(8'hD5), 0, 1, 0, 0);
      for (int i = 0; i < n; i++) begin
        if (drop_at >= 0 && i == drop_at) begin
          add_rec(10'h010, 1, 1, 0, 1);
          aborted = 1'b1;
          break;
        end
        b = frm[i] + 8'(r);
        body.push_back(b);
        add_rec(enc(b), 1, 1, 0, 0);
      end
      if (!aborted) begin
        for (int p = n; p < min_len; p++) begin
          body.push_back(8'h00);
          add_rec(enc(8'h00), 0, 1, 0, 0);
        end
        fcs = use_fixed ? fixed_fcs : ~sw_crc(body);
        add_rec(enc(fcs[7:0]),   0, 1, 0, 0);
        add_rec(enc(fcs[15:8]),  0, 1, 0, 0);
        add_rec(enc(fcs[23:16]), 0, 1, 0, 0);
        add_rec(enc(fcs[31:24]), 0, 1, 1, 0);
      end
      for (int g = 0; g < IFG_N; g++) add_rec(10'h000, 0, 1, 0, 0);
    end
    add_rec(10'h000, 0, 0, 0, 0);
    add_rec(10'h000, 0, 0, 0, 0);

    idx = 0; hs_prev = 1'b0; dropped = 1'b0;
    drive_step(drop_at);
    for (int j = 1; j < r_out.size(); j++) begin
      @(negedge clk);
      checkOutput($sformatf("%s[%0d]", tag, j),
                  {18'h0, cur_ready, cur_busy, cur_under, cur_done, cur_tx},
                  {18'h0, r_ready[j], r_busy[j], r_under[j-1], r_done[j-1], r_out[j-1]});
      drive_step(drop_at);
    end
    drv_valid = 1'b0; drv_last = 1'b0;
  endtask

  logic [7:0] q[$];
  logic       en_seen;
  int         sent;
  bit         hs;

  initial begin
    #2 rst = 1'b1;
    #1 checkOutput("rst_async", {10'h0, tx_pad, busy_pad, bus_pad.s_ready, under_pad, done_pad,
                                 tx_raw, busy_raw, bus_raw.s_ready}, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    en_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      en_seen = en_seen | tx_pad[4] | tx_pad[9] | tx_raw[4] | tx_raw[9] | busy_pad | busy_raw;
    end
    checkOutput("idle_no_en", {31'h0, en_seen}, 32'h0);

    sel = 1;
    @(negedge clk);
    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    applyStimulus("crc", q, 1, -1, 0, 1'b1, 32'hCBF43926);

    sel = 0;
    @(negedge clk);
    q.delete();
    for (int i = 0; i < 14; i++) q.push_back(8'(8'hA0 + i));
    applyStimulus("pad", q, 1, -1, 60, 1'b0, 32'h0);

    q.delete();
    for (int i = 0; i < 100; i++) q.push_back(8'(i * 3 + 1));
    applyStimulus("under", q, 1, 20, 60, 1'b0, 32'h0);

    q.delete();
    for (int i = 0; i < 60; i++) q.push_back(8'(8'hFF - i));
    applyStimulus("after_under", q, 1, -1, 60, 1'b0, 32'h0);

    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(8'(i));
    applyStimulus("b2b", q, 2, -1, 60, 1'b0, 32'h0);

    @(negedge clk);
    sent = 0; hs = 1'b0;
    drv_valid = 1'b1; drv_last = 1'b0;
    for (int k = 0; k < 300 && sent < 30; k++) begin
      drv_data = 8'(sent);
      hs = cur_ready;
      @(negedge clk);
      if (hs) sent++;
    end
    checkOutput("rst_reach_byte30", 32'(sent), 32'd30);
    #1 rst = 1'b1;
    #1 checkOutput("rst_mid_data", {20'h0, cur_tx, cur_ready, cur_busy}, 32'h0);
    drv_valid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'(8'h5A ^ i));
    applyStimulus("post_rst", q, 1, -1, 60, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
